// File: rtl/clock_alarm_timer_if.sv
// Signal bundle for clock_alarm_timer.
//   iclk_sec     : 1 Hz square wave, asynchronous to the system clock
//   ikey[3:0]    : active-low keys ([3] mode, [2] hour+, [1] min+, [0] alarm enable/stop)
//   ohour/omin/osec        : current time, packed BCD
//   oalarm_hour/oalarm_min : alarm setting, packed BCD
//   omode        : 0 = RUN, 1 = SET_TIME, 2 = SET_ALARM
//   oalarm_en    : alarm armed
//   oring        : alarm ringing
//   okey_count   : accepted key presses, packed BCD 00..99
// The slave modport is the clock block; the master modport is whatever drives
// the keys and the seconds wave and watches the displays.
interface clock_alarm_timer_if;
  logic       iclk_sec;
  logic [3:0] ikey;
  logic [7:0] ohour;
  logic [7:0] omin;
  logic [7:0] osec;
  logic [7:0] oalarm_hour;
  logic [7:0] oalarm_min;
  logic [1:0] omode;
  logic       oalarm_en;
  logic       oring;
  logic [7:0] okey_count;

  modport slave (
    input  iclk_sec, ikey,
    output ohour, omin, osec, oalarm_hour, oalarm_min,
    output omode, oalarm_en, oring, okey_count
  );

  modport master (
    output iclk_sec, ikey,
    input  ohour, omin, osec, oalarm_hour, oalarm_min,
    input  omode, oalarm_en, oring, okey_count
  );
endinterface

// File: rtl/clock_alarm_timer.sv
// Digital clock with settable time, one daily alarm and a key-press counter.
// Ports:
//   iclk   : system clock, the only clock used inside
//   irst_n : asynchronous active-low reset
//   bus    : clock_alarm_timer_if.slave (seconds wave and keys in, displays out)
// The seconds wave and every key are resynchronised through 3 flops; a falling
// edge seen between the two oldest stages becomes a single-cycle event.
module clock_alarm_timer #(
  parameter int HOURS      = 24,
  parameter int ALARM_SECS = 30
) (
  input  logic                 iclk,
  input  logic                 irst_n,
  clock_alarm_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_e;

  localparam logic [7:0] HOUR_MAX = 8'(HOURS - 1);
  localparam logic [7:0] RING_LEN = 8'(ALARM_SECS);

  logic [2:0]      sec_sync_q;
  logic [3:0][2:0] key_sync_q;
  logic            sec_ev;
  logic [3:0]      key_ev;

  mode_e      mode_q, mode_d;
  logic [7:0] hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [7:0] alarm_hour_q, alarm_hour_d, alarm_min_q, alarm_min_d;
  logic       alarm_en_q, alarm_en_d;
  logic       ring_q, ring_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic [7:0] key_cnt_q, key_cnt_d;
  logic       key_accepted;

  function automatic logic [7:0] inc_wrap(input logic [7:0] v, input logic [7:0] vmax);
    return (v == vmax) ? 8'd0 : 8'(v + 8'd1);
  endfunction

  // Values never exceed 99, so tens fit in the upper nibble without overflow.
  function automatic logic [7:0] to_bcd(input logic [7:0] v);
    return ((v / 8'd10) << 4) | (v % 8'd10);
  endfunction

  assign sec_ev = sec_sync_q[2] & ~sec_sync_q[1];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      key_ev[i] = key_sync_q[i][2] & ~key_sync_q[i][1];
    end
  end

  always_comb begin
    mode_d       = mode_q;
    hour_d       = hour_q;
    min_d        = min_q;
    sec_d        = sec_q;
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    alarm_en_d   = alarm_en_q;
    ring_d       = ring_q;
    ring_cnt_d   = ring_cnt_q;
    key_cnt_d    = key_cnt_q;
    key_accepted = 1'b0;

    // Time keeps running while the alarm is being edited; only SET_TIME freezes it.
    if (sec_ev && mode_q != MODE_SET_TIME) begin
      if (sec_q == 8'd59) begin
        sec_d = 8'd0;
        if (min_q == 8'd59) begin
          min_d  = 8'd0;
          hour_d = inc_wrap(hour_q, HOUR_MAX);
        end else begin
          min_d = 8'(min_q + 8'd1);
        end
      end else begin
        sec_d = 8'(sec_q + 8'd1);
      end
    end

    if (sec_ev && ring_q) begin
      if (ring_cnt_q <= 8'd1) ring_d = 1'b0;
      else                    ring_cnt_d = 8'(ring_cnt_q - 8'd1);
    end

    // A tick landing on hh:mm:00 of the alarm starts the ring; a mode or stop
    // key in the same cycle would cancel it at once, so it is not started.
    if (sec_ev && mode_q == MODE_RUN && alarm_en_q && !key_ev[3] && !key_ev[0] &&
        sec_q == 8'd59 && min_d == alarm_min_q && hour_d == alarm_hour_q) begin
      ring_d     = 1'b1;
      ring_cnt_d = RING_LEN;
    end

    case (mode_q)
      MODE_RUN: begin
        if (key_ev[0]) begin
          key_accepted = 1'b1;
          if (ring_q) ring_d     = 1'b0;
          else        alarm_en_d = ~alarm_en_q;
        end
      end
      MODE_SET_TIME: begin
        if (key_ev[2]) begin
          hour_d       = inc_wrap(hour_q, HOUR_MAX);
          key_accepted = 1'b1;
        end
        if (key_ev[1]) begin
          min_d        = inc_wrap(min_q, 8'd59);
          key_accepted = 1'b1;
        end
      end
      MODE_SET_ALARM: begin
        if (key_ev[2]) begin
          alarm_hour_d = inc_wrap(alarm_hour_q, HOUR_MAX);
          key_accepted = 1'b1;
        end
        if (key_ev[1]) begin
          alarm_min_d  = inc_wrap(alarm_min_q, 8'd59);
          key_accepted = 1'b1;
        end
      end
      default: ;
    endcase

    // Mode step is applied last so entry into SET_TIME overrides the tick's seconds
    // while keeping any minute/hour carry that tick produced.
    if (key_ev[3]) begin
      key_accepted = 1'b1;
      ring_d       = 1'b0;
      case (mode_q)
        MODE_RUN: begin
          mode_d = MODE_SET_TIME;
          sec_d  = 8'd0;
        end
        MODE_SET_TIME:  mode_d = MODE_SET_ALARM;
        default:        mode_d = MODE_RUN;
      endcase
    end

    if (!alarm_en_d) ring_d = 1'b0;

    if (key_accepted) key_cnt_d = (key_cnt_q == 8'd99) ? 8'd0 : 8'(key_cnt_q + 8'd1);
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      sec_sync_q   <= '1;
      key_sync_q   <= '1;
      mode_q       <= MODE_RUN;
      hour_q       <= '0;
      min_q        <= '0;
      sec_q        <= '0;
      alarm_hour_q <= '0;
      alarm_min_q  <= '0;
      alarm_en_q   <= 1'b0;
      ring_q       <= 1'b0;
      ring_cnt_q   <= '0;
      key_cnt_q    <= '0;
    end else begin
      sec_sync_q <= {sec_sync_q[1:0], bus.iclk_sec};
      for (int i = 0; i < 4; i++) begin
        key_sync_q[i] <= {key_sync_q[i][1:0], bus.ikey[i]};
      end
      mode_q       <= mode_d;
      hour_q       <= hour_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      alarm_en_q   <= alarm_en_d;
      ring_q       <= ring_d;
      ring_cnt_q   <= ring_cnt_d;
      key_cnt_q    <= key_cnt_d;
    end
  end

  assign bus.ohour       = to_bcd(hour_q);
  assign bus.omin        = to_bcd(min_q);
  assign bus.osec        = to_bcd(sec_q);
  assign bus.oalarm_hour = to_bcd(alarm_hour_q);
  assign bus.oalarm_min  = to_bcd(alarm_min_q);
  assign bus.omode       = mode_q;
  assign bus.oalarm_en   = alarm_en_q;
  assign bus.oring       = ring_q;
  assign bus.okey_count  = to_bcd(key_cnt_q);

endmodule

// File: doc/clock_alarm_timer.md
CLOCK_ALARM_TIMER -- requirements
Module: clock_alarm_timer

Interface
REQ-001 Parameter HOURS, default 24, hour modulus (legal values 12 or 24); hour counts 0..HOURS-1.
REQ-002 Parameter ALARM_SECS, default 30, ring duration in seconds (legal range 1..255).
REQ-003 iclk  in  1  system clock (e.g. 50 MHz); the block SHALL use one clock.
REQ-004 irst_n  in  1  reset, asynchronous, active-low.
REQ-005 iclk_sec  in  1  1 Hz square wave, asynchronous to iclk.
REQ-006 ikey  in  4  active-low keys: [3] mode, [2] hour+, [1] min+, [0] alarm enable/stop.
REQ-007 ohour, omin, osec  out  8 each  current time, packed BCD (tens [7:4], units [3:0]).
REQ-008 oalarm_hour, oalarm_min  out  8 each  alarm setting, packed BCD.
REQ-009 omode  out  2  0=RUN, 1=SET_TIME, 2=SET_ALARM.
REQ-010 oalarm_en  out  1  alarm armed.
REQ-011 oring  out  1  alarm ringing.
REQ-012 okey_count  out  8  accepted key presses, packed BCD, 00..99.

Function
REQ-013 iclk_sec and each ikey bit SHALL pass through a 3-flop shift register; an event SHALL be a 1-cycle pulse on a 1->0 transition between the two oldest stages.
REQ-014 Tick: each iclk_sec event advances seconds; 59->0 carries to minutes; 59->0 carries to hours; HOURS-1 wraps to 0.
REQ-015 Ticks SHALL advance time in RUN and SET_ALARM; in SET_TIME seconds SHALL be held and ticks ignored.
REQ-016 Mode FSM: a mode-key event SHALL step RUN->SET_TIME->SET_ALARM->RUN; no other transitions.
REQ-017 On entry to SET_TIME, seconds SHALL clear to 0 on the same edge as the state change.
REQ-018 SET_TIME: hour+ increments hour (wrap HOURS-1->0); min+ increments minute (wrap 59->0, no carry into hour).
REQ-019 SET_ALARM: hour+/min+ modify the alarm hour/minute with the same wrap rules; time is unaffected.
REQ-020 RUN: hour+/min+ SHALL be ignored and not counted.
REQ-021 Key ikey[0] in RUN: if oring=1, clear oring; otherwise toggle oalarm_en; ignored in other modes.
REQ-022 key count SHALL increment by 1 per accepted event (mode key always; others only when acted on), 99->0 wrap; simultaneous events in one cycle count once.
REQ-023 Ring start: in RUN with oalarm_en=1, when a tick produces hh:mm:00 equal to alarm hh:mm, oring SHALL be 1 from the next cycle.
REQ-024 Ring stop: oring SHALL clear after ALARM_SECS further ticks, on stop key, on any mode-key event, or when oalarm_en clears, whichever first.
REQ-025 Setting the time via SET_TIME to equal the alarm SHALL NOT start ringing; only a tick can.
REQ-026 Simultaneous tick and mode-key event in RUN: both SHALL take effect (time advances, state becomes SET_TIME with seconds cleared).
REQ-027 BCD outputs SHALL be combinational from binary registers (tens = v/10, units = v%10).

Reset
REQ-028 irst_n=0 SHALL immediately force: time 00:00:00, alarm 00:00, omode=0, oalarm_en=0, oring=0, key count 0, all sync flops to 1 (no spurious event on release).
REQ-029 Reset asserted mid-ring or mid-setting SHALL abort that activity; no state survives.
REQ-030 Registers SHALL leave reset state only on the first iclk edge after irst_n rises.

Verification
REQ-031 Time 23:59:58, RUN, two ticks -> 23:59:59 then 00:00:00; HOURS=12 run with 11:59:59 + tick -> 00:00:00.
REQ-032 Mode key x1, min+ x3, tick x5 -> omode=1, osec=00, omin advanced by 3, okey_count=04.
REQ-033 Alarm 07:30, enabled, time 07:29:59, tick -> oring=1 next cycle; ALARM_SECS=3, 3 more ticks -> oring=0.
REQ-034 Ringing, press ikey[0] -> oring=0 within 1 cycle, oalarm_en stays 1; press again -> oalarm_en=0.
REQ-035 RUN, press hour+ and min+ x5 each -> time unchanged by keys, okey_count=00; 150 mode presses -> okey_count=50.
REQ-036 Assert irst_n low mid-ring and mid-SET_ALARM -> all outputs at reset values same cycle, no event after release.
